pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an exact multiple of STAGES; SEG = WIDTH/STAGES bits per stage.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH  operands, unsigned or two's-complement.
REQ-008 cin  input  1  carry-in for add; borrow-in for subtract.
REQ-009 op  input  1  0 = add, 1 = subtract.
REQ-010 out_valid  output  1  result beat presented.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow.
REQ-015 busy  output  1  high while any stage holds a valid beat.

Function
REQ-016 op=0 SHALL compute {cout,sum} = a + b + cin; op=1 SHALL compute a + ~b + ~cin, i.e. a - b - cin, with cout=1 meaning no borrow.
REQ-017 ovf SHALL be 1 when both effective operands (a, and b or ~b) have equal MSBs and sum MSB differs from them.
REQ-018 Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-019 Unprocessed upper operand bits and completed lower sum bits SHALL be registered alongside each stage, so no stage holds more than one SEG-bit carry chain.
REQ-020 A beat transfers in when in_valid && in_ready; a beat transfers out when out_valid && out_ready.
REQ-021 advance = !out_valid || out_ready; in_ready SHALL equal advance; all stages shift together when advance=1 and hold when advance=0.
REQ-022 Latency SHALL be exactly STAGES cycles from accept to out_valid when advance stays 1; throughput 1 beat/cycle.
REQ-023 Bubbles SHALL propagate as invalid stages and are not collapsed.
REQ-024 sum, cout, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Results SHALL emerge in acceptance order; no beat dropped or duplicated.
REQ-026 In-flight op SHALL travel with its beat; mixing add/sub on consecutive beats is legal.
REQ-027 busy = OR of all stage valid bits.

Reset
REQ-028 rst_n=0 at a rising edge SHALL clear every stage valid bit and all data, carry and op registers to 0.
REQ-029 During and the cycle after reset: out_valid=0, sum=0, cout=0, ovf=0, busy=0, in_ready=1.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.

Structure
REQ-031 Shared package pipe_addsub_pkg SHALL hold OP_ADD=1'b0, OP_SUB=1'b1 and the stage-register bundle typedef (valid, op, carry, partial sum, remaining operands).
REQ-032 One sub-module seg_add (SEG-bit combinational add with carry in/out) SHALL be instantiated once per stage; all registers live in pipe_addsub.

Verification (WIDTH=32, STAGES=4 unless stated)
REQ-033 a=0xFFFFFFFF, b=1, cin=0, op=0, out_ready=1 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-034 a=0x7FFFFFFF, b=1, op=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-035 a=5, b=7, cin=0, op=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-036 8 back-to-back beats, out_ready=0 for 3 cycles mid-stream -> in_ready=0 and outputs frozen while stalled; all 8 results correct, in order.
REQ-037 rst_n=0 for 1 cycle with 3 beats in flight -> next cycle out_valid=0, busy=0; no stale beat emerges afterward.
REQ-038 WIDTH=8, STAGES=1: a=0x80, b=0x01, cin=0, op=1 -> 1 cycle later sum=0x7F, cout=1, ovf=1.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg: shared opcodes, stage-register bundle and overflow helper for pipe_addsub.
// The stage bundle is sized for the widest supported datapath (MAX_WIDTH); narrower
// instances simply leave the upper bits at zero.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 valid;
        logic                 op;
        logic                 carry;
        logic                 ovf;
        logic [MAX_WIDTH-1:0] psum;
        logic [MAX_WIDTH-1:0] a_rem;
        logic [MAX_WIDTH-1:0] b_rem;
    } stage_t;

    function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipe_addsub_seg.sv
// seg_add: W-bit combinational adder with carry in/out, one per pipeline stage.
// Ports: i_a, i_b operands; i_ci carry in; o_s sum; o_co carry out.
module seg_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co
);
    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep segmented add/subtract pipeline with valid/ready flow control.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b, cin, op input beat;
// out_valid/out_ready + sum, cout, ovf result beat; busy = any stage occupied.
// Subtract is a + ~b + ~cin, so cout=1 means no borrow.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int SEG = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGES and at most MAX_WIDTH");
    end

    stage_t r_stg [STAGES];
    stage_t w_src [STAGES];
    stage_t w_nxt [STAGES];
    logic   w_adv;
    logic   w_busy;

    assign w_adv     = !r_stg[STAGES-1].valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_stg[STAGES-1].valid;
    assign sum       = r_stg[STAGES-1].psum[WIDTH-1:0];
    assign cout      = r_stg[STAGES-1].carry;
    assign ovf       = r_stg[STAGES-1].ovf;
    assign busy      = w_busy;

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < STAGES; i++) w_busy = w_busy | r_stg[i].valid;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [SEG-1:0] w_ea;
        logic [SEG-1:0] w_eb;
        logic [SEG-1:0] w_s;
        logic           w_co;
        stage_t         w_n;

        // Stage 0 takes the raw beat; the carry-in is inverted for subtract.
        if (k == 0) begin : g_in
            assign w_src[k] = '{valid: in_valid, op: op, carry: (op == OP_SUB) ? ~cin : cin,
                                ovf: 1'b0, psum: '0, a_rem: MAX_WIDTH'(a), b_rem: MAX_WIDTH'(b)};
        end else begin : g_mid
            assign w_src[k] = r_stg[k-1];
        end

        // Operands are kept right-aligned so each stage always works on the low SEG bits.
        assign w_ea = w_src[k].a_rem[SEG-1:0];
        assign w_eb = (w_src[k].op == OP_SUB) ? ~w_src[k].b_rem[SEG-1:0] : w_src[k].b_rem[SEG-1:0];

        seg_add #(.W(SEG)) u_seg (
            .i_a  (w_ea),
            .i_b  (w_eb),
            .i_ci (w_src[k].carry),
            .o_s  (w_s),
            .o_co (w_co)
        );

        always_comb begin
            w_n       = w_src[k];
            w_n.carry = w_co;
            w_n.psum  = w_src[k].psum | (MAX_WIDTH'(w_s) << (k * SEG));
            w_n.a_rem = w_src[k].a_rem >> SEG;
            w_n.b_rem = w_src[k].b_rem >> SEG;
            w_n.ovf   = (k == STAGES - 1) ? ovf_of(w_ea[SEG-1], w_eb[SEG-1], w_s[SEG-1]) : 1'b0;
        end

        assign w_nxt[k] = w_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_stg[i] <= '0;
        end else if (w_adv) begin
            r_stg <= w_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed self-checking bench for pipe_addsub (32/4 and 8/1 instances).
module tb_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, op = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, busy;
    logic [31:0] sum;

    logic        in_valid8 = 1'b0, cin8 = 1'b0, op8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, cout8, ovf8, busy8;
    logic [7:0]  sum8;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .busy(busy)
    );

    pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .cin(cin8), .op(op8), .out_valid(out_valid8), .out_ready(1'b1), .sum(sum8),
        .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, input logic to, input logic [31:0] es,
                           input logic ec, input logic eo);
        a = ta; b = tb; cin = tc; op = to; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, ".latency"}, 64'(out_valid), 64'd0);
            chk({tag, ".busy"}, 64'(busy), 64'd1);
            step;
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".sum"}, 64'(sum), 64'(es));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
        step;
        chk({tag, ".drained"}, 64'(busy), 64'd0);
    endtask

    logic [31:0] va [8] = '{32'h1, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                            32'h0, 32'h00FF00FF, 32'd100, 32'h7FFFFFFF};
    logic [31:0] vb [8] = '{32'h2, 32'hFFFFFFFF, 32'h11111111, 32'h80000000,
                            32'h1, 32'h0F0F0F0F, 32'd100, 32'hFFFFFFFF};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vo [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] vs [8] = '{32'h3, 32'hFFFFFFFF, 32'h01234567, 32'h0,
                            32'hFFFFFFFF, 32'h100E100E, 32'hFFFFFFFF, 32'h80000000};
    logic        vco[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vov[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int ii;
        int oi;
        logic [31:0] held;

        // reset state
        step;
        step;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.sum", 64'(sum), 64'd0);
        chk("rst.cout", 64'(cout), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid8", 64'(out_valid8), 64'd0);
        chk("rst.sum8", 64'(sum8), 64'd0);
        rst_n = 1'b1;
        step;
        chk("post_rst.out_valid", 64'(out_valid), 64'd0);

        // single beats with exact latency
        run_one("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_one("posovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_one("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_one("cin_chain", 32'h0000FFFF, 32'h1, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0);
        run_one("sub_ovf", 32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_one("sub_borrow_in", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // 8 back-to-back beats, consumer stalls for cycles 5..7
        ii = 0;
        oi = 0;
        held = '0;
        for (int c = 0; c < 40 && oi < 8; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid = (ii < 8);
            if (ii < 8) begin
                a = va[ii]; b = vb[ii]; cin = vc[ii]; op = vo[ii];
            end
            #1;
            if (!out_ready) begin
                chk("stall.in_ready", 64'(in_ready), 64'd0);
                chk("stall.out_valid", 64'(out_valid), 64'd1);
                chk("stall.sum", 64'(sum), 64'(vs[oi]));
                if (c > 5) chk("stall.frozen", 64'(sum), 64'(held));
                held = sum;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream.sum[%0d]", oi), 64'(sum), 64'(vs[oi]));
                chk($sformatf("stream.cout[%0d]", oi), 64'(cout), 64'(vco[oi]));
                chk($sformatf("stream.ovf[%0d]", oi), 64'(ovf), 64'(vov[oi]));
                oi++;
            end
            if (in_valid && in_ready) ii++;
            step;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream.count", 64'(oi), 64'd8);
        step;
        chk("stream.idle", 64'(busy), 64'd0);

        // reset with 3 beats in flight
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; op = vo[i]; in_valid = 1'b1;
            step;
        end
        in_valid = 1'b0;
        chk("midrst.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("midrst.no_stale", 64'(out_valid), 64'd0);
        end

        // 8-bit single-stage instance
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; op8 = 1'b1; in_valid8 = 1'b1;
        step;
        in_valid8 = 1'b0;
        chk("w8.sub.out_valid", 64'(out_valid8), 64'd1);
        chk("w8.sub.sum", 64'(sum8), 64'h7F);
        chk("w8.sub.cout", 64'(cout8), 64'd1);
        chk("w8.sub.ovf", 64'(ovf8), 64'd1);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; op8 = 1'b0; in_valid8 = 1'b1;
        step;
        in_valid8 = 1'b0;
        chk("w8.add.sum", 64'(sum8), 64'h80);
        chk("w8.add.cout", 64'(cout8), 64'd0);
        chk("w8.add.ovf", 64'(ovf8), 64'd1);
        step;
        chk("w8.idle", 64'(out_valid8), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
